// File: rtl/tx_fcs_insert.sv
// Transmit framing stage: zero-pads short frames to the minimum length and appends
// the CRC-32 FCS, merging FCS bytes into free lanes of the last payload word.
module tx_fcs_crc32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_i,
   input  logic [3:0]  keep_i,
   input  logic        valid_i,
   output logic [31:0] crc_o
);
   logic [31:0] crc_q, crc_d;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      crc_d = crc_q;
      if (valid_i)
         for (int i = 0; i < 4; i++)
            if (keep_i[i]) crc_d = crc_byte(crc_d, data_i[8*i +: 8]);
   end

   // Output reflects the current beat so the FCS is available on the beat that ends the input.
   assign crc_o = ~crc_d;

   always_ff @(posedge clk) begin
      if (rst) crc_q <= 32'hFFFF_FFFF;
      else     crc_q <= crc_d;
   end
endmodule

module tx_fcs_insert #(
   parameter bit ENABLE_PAD      = 1'b1,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_keep,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready
);
   localparam int          CW    = $clog2(MIN_FRAME_BYTES + 1) + 1;
   localparam logic [31:0] MIN_U = 32'(MIN_FRAME_BYTES);

   typedef enum logic [1:0] {S_DATA, S_PAD, S_FCS, S_TAIL} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   out_data_q, out_data_d, fcs_q, fcs_d;
   logic [3:0]    out_keep_q, out_keep_d;
   logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [2:0]    tail_n_q, tail_n_d;

   logic          load, crc_rst, crc_vld, pad_need, zero_fill;
   logic [31:0]   crc_data, crc, cnt_ext, lane_mask;
   logic [3:0]    crc_keep;
   logic [2:0]    n;

   function automatic logic [2:0] keep_count(input logic [3:0] k);
      case (k)
         4'hF:    return 3'd4;
         4'h7:    return 3'd3;
         4'h3:    return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [3:0] low_keep(input logic [2:0] c);
      case (c)
         3'd1:    return 4'h1;
         3'd2:    return 4'h3;
         3'd3:    return 4'h7;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] keep_mask(input logic [3:0] k);
      return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
   endfunction

   function automatic logic [CW-1:0] sat_add4(input logic [CW-1:0] c);
      logic [31:0] s;
      s = 32'(c) + 32'd4;
      return (s >= MIN_U) ? MIN_U[CW-1:0] : s[CW-1:0];
   endfunction

   assign load      = out_ready || !out_valid_q;
   assign in_ready  = (state_q == S_DATA) && load;
   assign crc_rst   = !rst || (state_q == S_FCS) || (state_q == S_TAIL);
   assign n         = keep_count(in_keep);
   assign cnt_ext   = 32'(cnt_q);
   assign pad_need  = ENABLE_PAD && ((cnt_ext + 32'(n)) < MIN_U);
   assign lane_mask = keep_mask(in_keep);
   assign zero_fill = in_last && pad_need;

   // CRC input steering kept apart from the FSM so the engine output is not in a loop with it.
   assign crc_vld  = load && (((state_q == S_DATA) && in_valid) || (state_q == S_PAD));
   assign crc_data = (state_q == S_PAD) ? 32'h0 : (zero_fill ? (in_data & lane_mask) : in_data);
   assign crc_keep = ((state_q == S_PAD) || zero_fill) ? 4'hF : in_keep;

   tx_fcs_crc32 u_crc (
      .clk     (clk),
      .rst     (crc_rst),
      .data_i  (crc_data),
      .keep_i  (crc_keep),
      .valid_i (crc_vld),
      .crc_o   (crc)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      fcs_d       = fcs_q;
      tail_n_d    = tail_n_q;
      if (load) begin
         out_valid_d = 1'b0;
         case (state_q)
            S_DATA: if (in_valid) begin
               out_valid_d = 1'b1;
               out_keep_d  = 4'hF;
               out_last_d  = 1'b0;
               out_data_d  = in_data;
               cnt_d       = sat_add4(cnt_q);
               if (in_last) begin
                  if (pad_need) begin
                     out_data_d = in_data & lane_mask;
                     if (cnt_ext + 32'd4 == MIN_U) begin
                        fcs_d   = crc;
                        state_d = S_FCS;
                     end else begin
                        state_d = S_PAD;
                     end
                  end else if (n == 3'd4) begin
                     fcs_d   = crc;
                     state_d = S_FCS;
                  end else begin
                     // Low FCS bytes fill the free lanes; the rest go out in the tail beat.
                     out_data_d = (in_data & lane_mask) | (crc << {n, 3'b000});
                     fcs_d      = crc >> {3'd4 - n, 3'b000};
                     tail_n_d   = n;
                     state_d    = S_TAIL;
                  end
               end
            end
            S_PAD: begin
               out_valid_d = 1'b1;
               out_data_d  = 32'h0;
               out_keep_d  = 4'hF;
               out_last_d  = 1'b0;
               cnt_d       = sat_add4(cnt_q);
               if (cnt_ext + 32'd4 == MIN_U) begin
                  fcs_d   = crc;
                  state_d = S_FCS;
               end
            end
            S_FCS: begin
               out_valid_d = 1'b1;
               out_data_d  = fcs_q;
               out_keep_d  = 4'hF;
               out_last_d  = 1'b1;
               cnt_d       = '0;
               state_d     = S_DATA;
            end
            S_TAIL: begin
               out_valid_d = 1'b1;
               out_data_d  = fcs_q;
               out_keep_d  = low_keep(tail_n_q);
               out_last_d  = 1'b1;
               cnt_d       = '0;
               state_d     = S_DATA;
            end
            default: state_d = S_DATA;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_DATA;
         cnt_q       <= '0;
         out_data_q  <= 32'h0;
         out_keep_q  <= 4'h0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         fcs_q       <= 32'h0;
         tail_n_q    <= 3'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         fcs_q       <= fcs_d;
         tail_n_q    <= tail_n_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
endmodule

// File: tb/tb_tx_fcs_insert.sv
// Directed and randomised bench for tx_fcs_insert; one padded and one unpadded instance.
module tb_tx_fcs_insert;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] in_data = '0;
   logic [3:0]  in_keep = '0;
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic        sel = 1'b0, rnd_ready = 1'b0;

   logic        p_in_ready, p_out_valid, p_out_last;
   logic [31:0] p_out_data;
   logic [3:0]  p_out_keep;
   logic        n_in_ready, n_out_valid, n_out_last;
   logic [31:0] n_out_data;
   logic [3:0]  n_out_keep;

   tx_fcs_insert #(.ENABLE_PAD(1'b1), .MIN_FRAME_BYTES(60)) dut_p (
      .clk(clk), .rst(rst_n), .in_data(in_data), .in_keep(in_keep),
      .in_valid(in_valid && sel), .in_last(in_last), .in_ready(p_in_ready),
      .out_data(p_out_data), .out_keep(p_out_keep), .out_valid(p_out_valid),
      .out_last(p_out_last), .out_ready(out_ready));

   tx_fcs_insert #(.ENABLE_PAD(1'b0), .MIN_FRAME_BYTES(60)) dut_n (
      .clk(clk), .rst(rst_n), .in_data(in_data), .in_keep(in_keep),
      .in_valid(in_valid && !sel), .in_last(in_last), .in_ready(n_in_ready),
      .out_data(n_out_data), .out_keep(n_out_keep), .out_valid(n_out_valid),
      .out_last(n_out_last), .out_ready(out_ready));

   wire        s_in_ready  = sel ? p_in_ready  : n_in_ready;
   wire        s_out_valid = sel ? p_out_valid : n_out_valid;
   wire        s_out_last  = sel ? p_out_last  : n_out_last;
   wire [31:0] s_out_data  = sel ? p_out_data  : n_out_data;
   wire [3:0]  s_out_keep  = sel ? p_out_keep  : n_out_keep;

   int errors = 0;
   int checks = 0;
   byte unsigned pl[$];
   logic [36:0]  exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_crc(input byte unsigned b[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Expected wire bytes: payload, zero pad, FCS little-endian, chopped into 4-byte beats.
   function automatic void model(input bit pad);
      byte unsigned b[$];
      logic [31:0] c, d;
      logic [3:0]  k;
      b = pl;
      if (pad) while (b.size() < 60) b.push_back(8'h00);
      c = ref_crc(b);
      for (int j = 0; j < 4; j++) b.push_back(c[8*j +: 8]);
      for (int i = 0; i < b.size(); i += 4) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++)
            if (i + j < b.size()) begin
               d[8*j +: 8] = b[i + j];
               k[j] = 1'b1;
            end
         exp_q.push_back({(i + 4 >= b.size()), k, d});
      end
   endfunction

   task automatic wait_accept();
      int t;
      bit ok;
      t = 0;
      ok = 1'b0;
      while (!ok && t < 2000) begin
         @(negedge clk);
         ok = s_in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      chk("in_accept", 64'(ok), 64'd1);
   endtask

   task automatic send();
      int nb;
      logic [31:0] d;
      logic [3:0]  k;
      nb = (pl.size() + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++)
            if (4*b + j < pl.size()) begin
               d[8*j +: 8] = pl[4*b + j];
               k[j] = 1'b1;
            end
         in_data  = d;
         in_keep  = k;
         in_last  = (b == nb - 1);
         in_valid = 1'b1;
         wait_accept();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic recv(input string tag);
      logic [36:0] e;
      int t, beat;
      beat = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!(s_out_valid && out_ready) && t < 4000);
         chk($sformatf("%s_beat%0d", tag, beat),
             64'({s_out_valid && out_ready, s_out_last, s_out_keep, s_out_data}),
             64'({1'b1, e}));
         beat++;
      end
   endtask

   task automatic run_frame(input string tag);
      fork
         send();
         recv(tag);
      join
      @(posedge clk);
      #1;
   endtask

   task automatic load_123456789();
      pl.delete();
      for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
   endtask

   task automatic push_test1_expect();
      exp_q.push_back({1'b0, 4'hF, 32'h3433_3231});
      exp_q.push_back({1'b0, 4'hF, 32'h3837_3635});
      exp_q.push_back({1'b0, 4'hF, 32'hF439_2639});
      exp_q.push_back({1'b1, 4'h1, 32'h0000_00CB});
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   logic [36:0] prev_out;
   logic        prev_stall = 1'b0;
   always @(negedge clk) begin
      if (rst_n && prev_stall) begin
         checks++;
         assert ({s_out_last, s_out_keep, s_out_data} === prev_out) else begin
            errors++;
            $error("FAIL stall_hold got %h expected %h", {s_out_last, s_out_keep, s_out_data}, prev_out);
         end
      end
      prev_stall <= rst_n && s_out_valid && !out_ready;
      prev_out   <= {s_out_last, s_out_keep, s_out_data};
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_p_outs", {p_out_valid, p_out_last, p_out_keep, p_out_data}, 64'd0);
      chk("rst_n_outs", {n_out_valid, n_out_last, n_out_keep, n_out_data}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Unpadded: "123456789" with FCS merged into the last word and a 1-byte tail.
      sel = 1'b0;
      load_123456789();
      push_test1_expect();
      run_frame("t1_123456789");

      pl.delete();
      for (int i = 0; i < 8; i++) pl.push_back(8'(i + 1));
      model(1'b0);
      chk("t2_beats", 64'(exp_q.size()), 64'd3);
      run_frame("t2_8byte");

      // Padded: 1-byte frame grows to 60 bytes plus FCS; 64-byte frame is left alone.
      sel = 1'b1;
      pl.delete();
      pl.push_back(8'hAB);
      model(1'b1);
      run_frame("t3_pad1");

      pl.delete();
      for (int i = 0; i < 64; i++) pl.push_back(8'(i * 7 + 3));
      model(1'b1);
      run_frame("t4_64byte");

      pl.delete();
      for (int i = 0; i < 58; i++) pl.push_back(8'(i + 9));
      model(1'b1);
      run_frame("t4b_58byte");

      // Random lengths with back-pressure on both instances.
      rnd_ready = 1'b1;
      for (int s = 0; s < 2; s++) begin
         sel = (s == 0);
         for (int f = 0; f < 50; f++) begin
            pl.delete();
            for (int i = 0; i < int'($urandom_range(1, 200)); i++) pl.push_back(8'($urandom));
            model(sel);
            run_frame($sformatf("rnd_s%0d_f%0d", s, f));
         end
      end
      rnd_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_after_rnd", 64'(s_out_valid), 64'd0);

      // Reset in the middle of padding, then a fresh frame.
      sel = 1'b1;
      pl.delete();
      pl.push_back(8'h5A);
      send();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midpad_rst_outs", {p_out_valid, p_out_last, p_out_keep, p_out_data}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      load_123456789();
      model(1'b1);
      run_frame("t6_after_rst_pad");
      sel = 1'b0;
      load_123456789();
      push_test1_expect();
      run_frame("t6_after_rst_nopad");

      repeat (3) @(posedge clk);
      #1;
      chk("final_idle", 64'(s_out_valid), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
